// File: rtl/adder_sched_pkg.sv
// Shared types and helpers for the round-robin adder scheduler.
package adder_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_N_REQ = 4;

    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/adder_core.sv
// Registered WIDTH-bit adder with carry out; result updates only when enabled.
module adder_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);

    logic [WIDTH:0] res_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            res_q <= '0;
        end else if (en_i) begin
            res_q <= {1'b0, a_i} + {1'b0, b_i};
        end
    end

    assign sum_o   = res_q[WIDTH-1:0];
    assign carry_o = res_q[WIDTH];

endmodule

// File: rtl/adder_rr_scheduler.sv
// Round-robin sharing of one registered adder among N_REQ valid/ready requesters.
//   state | meaning
//   IDLE  | scanning requests from rr_ptr, grant accepted this cycle
//   CALC  | captured operands being added
//   RESP  | result presented, waiting for rsp_ready
module adder_rr_scheduler
    import adder_sched_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [WIDTH-1:0]       rsp_sum,
    output logic                   rsp_carry,
    output logic                   busy
);

    state_e           state_q;
    logic [ID_W-1:0]  rr_ptr_q;
    logic [ID_W-1:0]  id_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             rsp_valid_q;

    logic             grant_vld;
    logic [ID_W-1:0]  grant_idx;
    logic [ID_W-1:0]  scan_idx;
    logic             accept;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
            if (!grant_vld && req_valid[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    // Gate on reset so no accept strobe is seen while reset is held.
    assign accept = (state_q == IDLE) && grant_vld && !reset;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= req_a[int'(grant_idx)*WIDTH +: WIDTH];
                        b_q     <= req_b[int'(grant_idx)*WIDTH +: WIDTH];
                        id_q    <= grant_idx;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rr_ptr_q    <= ID_W'(rr_next(int'(id_q), N_REQ));
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    adder_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .reset   (reset),
        .en_i    (state_q == CALC),
        .a_i     (a_q),
        .b_i     (b_q),
        .sum_o   (rsp_sum),
        .carry_o (rsp_carry)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Directed bench for adder_rr_scheduler: reset, single ops, overflow, fairness, backpressure, reset mid-op.
module tb_adder_rr_scheduler;

    localparam int N_REQ = 4;
    localparam int WIDTH = 4;
    localparam int ID_W  = 2;

    logic                   clk;
    logic                   reset;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ-1:0]       req_ready;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [WIDTH-1:0]       rsp_sum;
    logic                   rsp_carry;
    logic                   busy;

    int n_assert = 0;
    int n_fail   = 0;

    adder_rr_scheduler #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Issue one request from an idle scheduler with rsp_ready high and check every cycle.
    task automatic do_op(input int id, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] exp_sum, input logic exp_c);
        req_valid = 4'(1 << id);
        req_a[id*WIDTH +: WIDTH] = a;
        req_b[id*WIDTH +: WIDTH] = b;
        rsp_ready = 1'b1;
        #1;
        chk("op_req_ready", 32'(req_ready), 32'(1 << id));
        cyc();
        req_valid = '0;
        #1;
        chk("op_calc_ready", 32'(req_ready), 32'h0);
        chk("op_calc_busy", 32'(busy), 32'h1);
        chk("op_calc_rsp_valid", 32'(rsp_valid), 32'h0);
        cyc();
        chk("op_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("op_rsp_id", 32'(rsp_id), 32'(id));
        chk("op_rsp_sum", 32'(rsp_sum), 32'(exp_sum));
        chk("op_rsp_carry", 32'(rsp_carry), 32'(exp_c));
        cyc();
        chk("op_idle_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("op_idle_busy", 32'(busy), 32'h0);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        // 1: reset held with all requests valid, then first grant to id 0
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_req_ready", 32'(req_ready), 32'h0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
            chk("rst_busy", 32'(busy), 32'h0);
            chk("rst_rsp_sum", 32'(rsp_sum), 32'h0);
            chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        end
        reset = 1'b0;
        #1;
        chk("rst_first_grant", 32'(req_ready), 32'h1);
        cyc();
        req_valid = '0;
        cyc();
        chk("rst_op_valid", 32'(rsp_valid), 32'h1);
        chk("rst_op_id", 32'(rsp_id), 32'h0);
        chk("rst_op_sum", 32'(rsp_sum), 32'h0);
        cyc();

        // 2: single op on requester 2
        do_op(2, 4'h3, 4'h5, 4'h8, 1'b0);

        // 3: overflow cases; last op on id 3 leaves rr_ptr at 0
        do_op(1, 4'hF, 4'h1, 4'h0, 1'b1);
        do_op(0, 4'h9, 4'h9, 4'h2, 1'b1);
        do_op(3, 4'h7, 4'h8, 4'hF, 1'b0);

        // 4: fairness with all requests valid
        req_a     = 16'h4321;
        req_b     = 16'h1111;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            chk("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
            cyc();
            chk("rr_calc_ready", 32'(req_ready), 32'h0);
            cyc();
            chk("rr_resp_ready", 32'(req_ready), 32'h0);
            chk("rr_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("rr_rsp_id", 32'(rsp_id), 32'(k % 4));
            chk("rr_rsp_sum", 32'(rsp_sum), 32'((k % 4) + 2));
            cyc();
        end

        // 5: backpressure on a grant to id 0
        rsp_ready = 1'b0;
        #1;
        chk("bp_grant", 32'(req_ready), 32'h1);
        cyc();
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_rsp_id", 32'(rsp_id), 32'h0);
            chk("bp_rsp_sum", 32'(rsp_sum), 32'h2);
            chk("bp_rsp_carry", 32'(rsp_carry), 32'h0);
            chk("bp_req_ready", 32'(req_ready), 32'h0);
            chk("bp_busy", 32'(busy), 32'h1);
            cyc();
        end
        chk("bp_still_valid", 32'(rsp_valid), 32'h1);
        rsp_ready = 1'b1;
        cyc();
        chk("bp_release_valid", 32'(rsp_valid), 32'h0);
        chk("bp_release_busy", 32'(busy), 32'h0);
        chk("bp_next_grant", 32'(req_ready), 32'h2);
        req_valid = '0;

        // 6: reset while request 1 is in CALC
        #1;
        req_valid = 4'h2;
        req_a[1*WIDTH +: WIDTH] = 4'h6;
        req_b[1*WIDTH +: WIDTH] = 4'h6;
        #1;
        chk("rc_grant", 32'(req_ready), 32'h2);
        cyc();
        chk("rc_calc_busy", 32'(busy), 32'h1);
        req_valid = 4'h3;
        reset     = 1'b1;
        #1;
        chk("rc_ready_in_reset", 32'(req_ready), 32'h0);
        cyc();
        chk("rc_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rc_busy", 32'(busy), 32'h0);
        chk("rc_rsp_sum", 32'(rsp_sum), 32'h0);
        chk("rc_rsp_id", 32'(rsp_id), 32'h0);
        reset = 1'b0;
        #1;
        chk("rc_grant_after", 32'(req_ready), 32'h1);
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rc_no_rsp", 32'(rsp_valid), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
